// File: rtl/arbiter_wb8_pkg.sv
// Shared definitions for the two-master pipelined Wishbone arbiter.
// State encoding, timeout read data and counter limits.
package arbiter_wb8_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_e;

   localparam logic [7:0]  TIMEOUT_DATA = 8'hFF;
   localparam logic [15:0] CNT_MAX      = 16'hFFFF;

endpackage

// File: rtl/arbiter_wb8_bus_timeout_counter.sv
// Tracks whether the current owner has a transfer in flight and counts wait cycles;
// raises a one-cycle expiry pulse when the limit is reached without a slave ack.
module arbiter_wb8_bus_timeout_counter
   import arbiter_wb8_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic stb,
   input  logic stall,
   input  logic ack,
   output logic outstanding,
   output logic expire
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT);

   logic [15:0] count_r;
   logic        outstanding_r;
   logic        expire_s;

   // A real ack on the limit cycle wins over the timeout; an abandoned cycle never expires.
   always_comb begin
      expire_s = 1'b0;
      if (!clr && (count_r == LIMIT) && !ack) begin
         expire_s = 1'b1;
      end else begin
         expire_s = 1'b0;
      end
   end

   // Outstanding flag and saturating wait counter, both dropped on expiry or handover.
   always_ff @(posedge clk) begin
      if (reset || clr || expire_s) begin
         count_r       <= 16'd0;
         outstanding_r <= 1'b0;
      end else begin
         if (stb && !stall) begin
            outstanding_r <= 1'b1;
         end else if (ack) begin
            outstanding_r <= 1'b0;
         end else begin
            outstanding_r <= outstanding_r;
         end

         if (ack) begin
            count_r <= 16'd0;
         end else if ((stb || outstanding_r) && (count_r != CNT_MAX)) begin
            count_r <= count_r + 16'd1;
         end else begin
            count_r <= count_r;
         end
      end
   end

   assign outstanding = outstanding_r;
   assign expire      = expire_s;

endmodule

// File: rtl/arbiter_wb8.sv
// Two-master (CPU, DMA) arbiter for an 8-bit pipelined Wishbone bus with
// round-robin tie-break, no preemption and a bus timeout that returns 0xFF.
module arbiter_wb8
   import arbiter_wb8_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        I_wb_clk,
   input  logic        I_reset,
   input  logic        I_m0_cyc,
   input  logic        I_m0_stb,
   input  logic        I_m0_we,
   input  logic [31:0] I_m0_adr,
   input  logic [7:0]  I_m0_dat,
   output logic [7:0]  O_m0_dat,
   output logic        O_m0_ack,
   output logic        O_m0_stall,
   input  logic        I_m1_cyc,
   input  logic        I_m1_stb,
   input  logic        I_m1_we,
   input  logic [31:0] I_m1_adr,
   input  logic [7:0]  I_m1_dat,
   output logic [7:0]  O_m1_dat,
   output logic        O_m1_ack,
   output logic        O_m1_stall,
   output logic        O_s_cyc,
   output logic        O_s_stb,
   output logic        O_s_we,
   output logic [31:0] O_s_adr,
   output logic [7:0]  O_s_dat,
   input  logic [7:0]  I_s_dat,
   input  logic        I_s_ack,
   input  logic        I_s_stall,
   output logic [1:0]  O_grant,
   output logic        O_timeout
);

   state_e      state_r;
   logic        last_r;
   logic [1:0]  grant_r;
   logic        timeout_r;

   logic        own0_s;
   logic        own1_s;
   logic        own_cyc_s;
   logic        own_stb_s;
   logic        own_we_s;
   logic [31:0] own_adr_s;
   logic [7:0]  own_dat_s;
   logic        clr_s;
   logic        outstanding_s;
   logic        expire_s;
   logic        ack_ok_s;

   // Ownership FSM; last_r = 1 means m1 was served last, so m0 wins the next tie.
   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         state_r <= ST_IDLE;
         last_r  <= 1'b1;
         grant_r <= 2'b00;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (I_m0_cyc && (!I_m1_cyc || last_r)) begin
                  state_r <= ST_OWN0;
                  last_r  <= 1'b0;
                  grant_r <= 2'b01;
               end else if (I_m1_cyc) begin
                  state_r <= ST_OWN1;
                  last_r  <= 1'b1;
                  grant_r <= 2'b10;
               end else begin
                  state_r <= ST_IDLE;
                  last_r  <= last_r;
                  grant_r <= 2'b00;
               end
            end
            ST_OWN0: begin
               if (I_m0_cyc) begin
                  state_r <= ST_OWN0;
                  last_r  <= last_r;
                  grant_r <= 2'b01;
               end else if (I_m1_cyc) begin
                  state_r <= ST_OWN1;
                  last_r  <= 1'b1;
                  grant_r <= 2'b10;
               end else begin
                  state_r <= ST_IDLE;
                  last_r  <= last_r;
                  grant_r <= 2'b00;
               end
            end
            ST_OWN1: begin
               if (I_m1_cyc) begin
                  state_r <= ST_OWN1;
                  last_r  <= last_r;
                  grant_r <= 2'b10;
               end else if (I_m0_cyc) begin
                  state_r <= ST_OWN0;
                  last_r  <= 1'b0;
                  grant_r <= 2'b01;
               end else begin
                  state_r <= ST_IDLE;
                  last_r  <= last_r;
                  grant_r <= 2'b00;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               last_r  <= 1'b1;
               grant_r <= 2'b00;
            end
         endcase
      end
   end

   // Route the current owner's request onto the shared slave side.
   always_comb begin
      own_cyc_s = 1'b0;
      own_stb_s = 1'b0;
      own_we_s  = 1'b0;
      own_adr_s = 32'h0000_0000;
      own_dat_s = 8'h00;
      case (state_r)
         ST_OWN0: begin
            own_cyc_s = I_m0_cyc;
            own_stb_s = I_m0_stb;
            own_we_s  = I_m0_we;
            own_adr_s = I_m0_adr;
            own_dat_s = I_m0_dat;
         end
         ST_OWN1: begin
            own_cyc_s = I_m1_cyc;
            own_stb_s = I_m1_stb;
            own_we_s  = I_m1_we;
            own_adr_s = I_m1_adr;
            own_dat_s = I_m1_dat;
         end
         default: begin
            own_cyc_s = 1'b0;
            own_stb_s = 1'b0;
            own_we_s  = 1'b0;
            own_adr_s = 32'h0000_0000;
            own_dat_s = 8'h00;
         end
      endcase
   end

   // Dropping cyc ends ownership at the next edge, so tracking restarts for the next owner.
   assign clr_s = !own_cyc_s;

   arbiter_wb8_bus_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk         (I_wb_clk),
      .reset       (I_reset),
      .clr         (clr_s),
      .stb         (own_stb_s),
      .stall       (I_s_stall),
      .ack         (I_s_ack),
      .outstanding (outstanding_s),
      .expire      (expire_s)
   );

   // Sticky timeout indication, cleared only by reset.
   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         timeout_r <= 1'b0;
      end else if (expire_s) begin
         timeout_r <= 1'b1;
      end else begin
         timeout_r <= timeout_r;
      end
   end

   assign own0_s   = grant_r[0];
   assign own1_s   = grant_r[1];
   assign ack_ok_s = I_s_ack && outstanding_s;

   assign O_s_cyc    = own_cyc_s;
   assign O_s_stb    = own_stb_s && !expire_s;
   assign O_s_we     = own_we_s;
   assign O_s_adr    = own_adr_s;
   assign O_s_dat    = own_dat_s;

   assign O_m0_ack   = own0_s && (ack_ok_s || expire_s);
   assign O_m0_stall = own0_s ? I_s_stall : 1'b1;
   assign O_m0_dat   = (own0_s && expire_s) ? TIMEOUT_DATA : I_s_dat;
   assign O_m1_ack   = own1_s && (ack_ok_s || expire_s);
   assign O_m1_stall = own1_s ? I_s_stall : 1'b1;
   assign O_m1_dat   = (own1_s && expire_s) ? TIMEOUT_DATA : I_s_dat;

   assign O_grant    = grant_r;
   assign O_timeout  = timeout_r;

endmodule

// File: tb/tb_arbiter_wb8.sv
// Directed bench for arbiter_wb8 (TIMEOUT = 8): per-cycle vector table plus
// hand-written sequences for ack-on-expiry and reset during a transfer.
module tb_arbiter_wb8;

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [31:0] adr;
      logic [7:0]  dat;
   } mst_t;

   typedef struct packed {
      logic       rst;
      mst_t       m0;
      mst_t       m1;
      logic [7:0] s_dat;
      logic       s_ack;
      logic       s_stall;
   } in_t;

   typedef struct packed {
      logic [1:0] grant;
      mst_t       s;
      logic       m0_ack;
      logic       m0_stall;
      logic [7:0] m0_dat;
      logic       m1_ack;
      logic       m1_stall;
      logic [7:0] m1_dat;
      logic       tmo;
   } out_t;

   typedef struct {
      string name;
      in_t   i;
      out_t  o;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [31:0] m0_adr, m1_adr;
   logic [7:0]  m0_wdat, m1_wdat;
   logic [7:0]  m0_rdat, m1_rdat;
   logic        m0_ack, m0_stall, m1_ack, m1_stall;
   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_adr;
   logic [7:0]  s_wdat, s_rdat;
   logic        s_ack, s_stall;
   logic [1:0]  grant;
   logic        tmo;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   arbiter_wb8 #(.TIMEOUT(8)) dut (
      .I_wb_clk (clk),      .I_reset (reset),
      .I_m0_cyc (m0_cyc),   .I_m0_stb (m0_stb),     .I_m0_we (m0_we),
      .I_m0_adr (m0_adr),   .I_m0_dat (m0_wdat),    .O_m0_dat (m0_rdat),
      .O_m0_ack (m0_ack),   .O_m0_stall (m0_stall),
      .I_m1_cyc (m1_cyc),   .I_m1_stb (m1_stb),     .I_m1_we (m1_we),
      .I_m1_adr (m1_adr),   .I_m1_dat (m1_wdat),    .O_m1_dat (m1_rdat),
      .O_m1_ack (m1_ack),   .O_m1_stall (m1_stall),
      .O_s_cyc (s_cyc),     .O_s_stb (s_stb),       .O_s_we (s_we),
      .O_s_adr (s_adr),     .O_s_dat (s_wdat),
      .I_s_dat (s_rdat),    .I_s_ack (s_ack),       .I_s_stall (s_stall),
      .O_grant (grant),     .O_timeout (tmo)
   );

   function automatic mst_t mb(input logic c, input logic s, input logic w,
                               input logic [31:0] a, input logic [7:0] d);
      mst_t t;
      t.cyc = c; t.stb = s; t.we = w; t.adr = a; t.dat = d;
      return t;
   endfunction

   function automatic in_t ei(input logic r, input mst_t a, input mst_t b,
                              input logic [7:0] sd, input logic sa, input logic ss);
      in_t t;
      t.rst = r; t.m0 = a; t.m1 = b; t.s_dat = sd; t.s_ack = sa; t.s_stall = ss;
      return t;
   endfunction

   function automatic out_t eo(input logic [1:0] g, input mst_t b,
                               input logic a0, input logic st0, input logic [7:0] d0,
                               input logic a1, input logic st1, input logic [7:0] d1,
                               input logic t);
      out_t o;
      o.grant = g; o.s = b;
      o.m0_ack = a0; o.m0_stall = st0; o.m0_dat = d0;
      o.m1_ack = a1; o.m1_stall = st1; o.m1_dat = d1;
      o.tmo = t;
      return o;
   endfunction

   function automatic out_t sample();
      return eo(grant, mb(s_cyc, s_stb, s_we, s_adr, s_wdat),
                m0_ack, m0_stall, m0_rdat, m1_ack, m1_stall, m1_rdat, tmo);
   endfunction

   task automatic add(input string n, input in_t i, input out_t o);
      vec_t v;
      v.name = n; v.i = i; v.o = o;
      tbl.push_back(v);
   endtask

   task automatic drive(input in_t i);
      reset  = i.rst;
      m0_cyc = i.m0.cyc; m0_stb = i.m0.stb; m0_we = i.m0.we; m0_adr = i.m0.adr; m0_wdat = i.m0.dat;
      m1_cyc = i.m1.cyc; m1_stb = i.m1.stb; m1_we = i.m1.we; m1_adr = i.m1.adr; m1_wdat = i.m1.dat;
      s_rdat = i.s_dat; s_ack = i.s_ack; s_stall = i.s_stall;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", n, got, exp);
      end
   endtask

   initial begin
      mst_t z;
      out_t got;
      z = '0;

      // Idle and REQ-032 style read by m0 with a 2-cycle slave ack.
      add("rst_idle_ack_ign", ei(1'b0, z, z, 8'h33, 1'b1, 1'b0),
          eo(2'b00, z, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h33, 1'b0));
      add("m0_req", ei(1'b0, mb(1'b1, 1'b1, 1'b0, 32'h1000, 8'h00), z, 8'h00, 1'b0, 1'b0),
          eo(2'b00, z, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
      add("m0_grant", ei(1'b0, mb(1'b1, 1'b1, 1'b0, 32'h1000, 8'h00), z, 8'h00, 1'b0, 1'b0),
          eo(2'b01, mb(1'b1, 1'b1, 1'b0, 32'h1000, 8'h00), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
      add("m0_wait", ei(1'b0, mb(1'b1, 1'b0, 1'b0, 32'h1000, 8'h00), z, 8'h00, 1'b0, 1'b0),
          eo(2'b01, mb(1'b1, 1'b0, 1'b0, 32'h1000, 8'h00), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
      add("m0_ack_5a", ei(1'b0, mb(1'b1, 1'b0, 1'b0, 32'h1000, 8'h00), z, 8'h5A, 1'b1, 1'b0),
          eo(2'b01, mb(1'b1, 1'b0, 1'b0, 32'h1000, 8'h00), 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0));
      add("m0_drop", ei(1'b0, z, z, 8'h00, 1'b0, 1'b0),
          eo(2'b01, z, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
      add("back_idle", ei(1'b0, z, z, 8'h00, 1'b0, 1'b0),
          eo(2'b00, z, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
      add("rst_again", ei(1'b1, z, z, 8'h00, 1'b0, 1'b0),
          eo(2'b00, z, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));

      // Ties after reset: m0 first, handover without IDLE gap, then alternation.
      add("tie_req", ei(1'b0, mb(1'b1, 1'b0, 1'b0, 32'h0, 8'h00), mb(1'b1, 1'b0, 1'b0, 32'h2000, 8'h00), 8'h00, 1'b0, 1'b0),
          eo(2'b00, z, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
      add("tie_m0", ei(1'b0, mb(1'b1, 1'b0, 1'b0, 32'h0, 8'h00), mb(1'b1, 1'b0, 1'b0, 32'h2000, 8'h00), 8'h00, 1'b0, 1'b0),
          eo(2'b01, mb(1'b1, 1'b0, 1'b0, 32'h0, 8'h00), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
      add("m0_lets_go", ei(1'b0, z, mb(1'b1, 1'b0, 1'b0, 32'h2000, 8'h00), 8'h00, 1'b0, 1'b0),
          eo(2'b01, z, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
      add("handover_m1", ei(1'b0, mb(1'b1, 1'b0, 1'b0, 32'h0, 8'h00), mb(1'b1, 1'b0, 1'b0, 32'h2000, 8'h00), 8'h00, 1'b0, 1'b0),
          eo(2'b10, mb(1'b1, 1'b0, 1'b0, 32'h2000, 8'h00), 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
      add("both_drop", ei(1'b0, z, z, 8'h00, 1'b0, 1'b0),
          eo(2'b10, z, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
      for (int k = 0; k < 3; k++) begin
         add("tieN_req", ei(1'b0, mb(1'b1, 1'b0, 1'b0, 32'h0, 8'h00), mb(1'b1, 1'b0, 1'b0, 32'h2000, 8'h00), 8'h00, 1'b0, 1'b0),
             eo(2'b00, z, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
         if (k == 1)
            add("tieN_m1", ei(1'b0, z, z, 8'h00, 1'b0, 1'b0),
                eo(2'b10, z, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
         else
            add("tieN_m0", ei(1'b0, z, z, 8'h00, 1'b0, 1'b0),
                eo(2'b01, z, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
      end

      // m1 burst of 4 pipelined writes; m0 requests mid-burst and waits.
      add("m1_req", ei(1'b0, z, mb(1'b1, 1'b1, 1'b1, 32'h3000, 8'hA0), 8'h00, 1'b0, 1'b0),
          eo(2'b00, z, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
      add("wr0", ei(1'b0, z, mb(1'b1, 1'b1, 1'b1, 32'h3000, 8'hA0), 8'h00, 1'b0, 1'b0),
          eo(2'b10, mb(1'b1, 1'b1, 1'b1, 32'h3000, 8'hA0), 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
      for (int k = 1; k < 4; k++) begin
         add("wrN", ei(1'b0, mb(1'b1, 1'b1, 1'b0, 32'h4000, 8'h00),
                       mb(1'b1, 1'b1, 1'b1, 32'h3000 + 32'(k), 8'hA0 + 8'(k)), 8'h00, 1'b1, 1'b0),
             eo(2'b10, mb(1'b1, 1'b1, 1'b1, 32'h3000 + 32'(k), 8'hA0 + 8'(k)),
                1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));
      end
      add("wr_last_ack", ei(1'b0, mb(1'b1, 1'b1, 1'b0, 32'h4000, 8'h00), mb(1'b1, 1'b0, 1'b0, 32'h0, 8'h00), 8'h00, 1'b1, 1'b0),
          eo(2'b10, mb(1'b1, 1'b0, 1'b0, 32'h0, 8'h00), 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));
      add("m1_release", ei(1'b0, mb(1'b1, 1'b1, 1'b0, 32'h4000, 8'h00), z, 8'h00, 1'b0, 1'b0),
          eo(2'b10, z, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));

      // m0 read that the slave never acks: expiry exactly 8 cycles after the strobe.
      add("m0_strobe", ei(1'b0, mb(1'b1, 1'b1, 1'b0, 32'h4000, 8'h00), z, 8'h11, 1'b0, 1'b0),
          eo(2'b01, mb(1'b1, 1'b1, 1'b0, 32'h4000, 8'h00), 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0));
      for (int k = 0; k < 7; k++) begin
         add("tmo_wait", ei(1'b0, mb(1'b1, 1'b0, 1'b0, 32'h4000, 8'h00), z, 8'h11, 1'b0, 1'b0),
             eo(2'b01, mb(1'b1, 1'b0, 1'b0, 32'h4000, 8'h00), 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0));
      end
      add("tmo_expire", ei(1'b0, mb(1'b1, 1'b1, 1'b0, 32'h4000, 8'h00), z, 8'h11, 1'b0, 1'b0),
          eo(2'b01, mb(1'b1, 1'b0, 1'b0, 32'h4000, 8'h00), 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h11, 1'b0));
      add("tmo_flag", ei(1'b0, mb(1'b1, 1'b0, 1'b0, 32'h4000, 8'h00), z, 8'h11, 1'b0, 1'b0),
          eo(2'b01, mb(1'b1, 1'b0, 1'b0, 32'h4000, 8'h00), 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1));
      add("tmo_release", ei(1'b0, z, z, 8'h11, 1'b0, 1'b0),
          eo(2'b01, z, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1));
      add("tmo_sticky", ei(1'b0, z, z, 8'h11, 1'b0, 1'b0),
          eo(2'b00, z, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1));

      drive(ei(1'b1, z, z, 8'h00, 1'b0, 1'b0));
      adv();
      adv();

      for (int k = 0; k < tbl.size(); k++) begin
         drive(tbl[k].i);
         @(negedge clk);
         got = sample();
         checks++;
         if (got !== tbl[k].o) begin
            errors++;
            $display("FAIL %s (row %0d) got %h exp %h", tbl[k].name, k, got, tbl[k].o);
         end
         adv();
      end

      // Slave ack lands on the expiry cycle: real data, no timeout flag.
      drive(ei(1'b1, z, z, 8'h00, 1'b0, 1'b0));
      adv();
      drive(ei(1'b0, z, z, 8'h00, 1'b0, 1'b0));
      @(negedge clk);
      chk("tmo_cleared_by_reset", 32'(tmo), 32'd0);
      adv();
      drive(ei(1'b0, mb(1'b1, 1'b1, 1'b0, 32'h5000, 8'h00), z, 8'h00, 1'b0, 1'b0));
      adv();
      @(negedge clk);
      chk("race_grant", 32'(grant), 32'd1);
      adv();
      drive(ei(1'b0, mb(1'b1, 1'b0, 1'b0, 32'h5000, 8'h00), z, 8'h00, 1'b0, 1'b0));
      repeat (7) adv();
      drive(ei(1'b0, mb(1'b1, 1'b0, 1'b0, 32'h5000, 8'h00), z, 8'h77, 1'b1, 1'b0));
      @(negedge clk);
      chk("race_ack", 32'(m0_ack), 32'd1);
      chk("race_data", 32'(m0_rdat), 32'h77);
      adv();
      drive(ei(1'b0, z, z, 8'h00, 1'b0, 1'b0));
      @(negedge clk);
      chk("race_no_tmo", 32'(tmo), 32'd0);
      adv();
      adv();

      // Reset during an outstanding m1 read; the late ack must not reach m1.
      drive(ei(1'b0, z, mb(1'b1, 1'b1, 1'b0, 32'h6000, 8'h00), 8'h00, 1'b0, 1'b0));
      adv();
      @(negedge clk);
      chk("m1_read_grant", 32'(grant), 32'd2);
      adv();
      drive(ei(1'b1, z, mb(1'b1, 1'b0, 1'b0, 32'h6000, 8'h00), 8'h00, 1'b0, 1'b0));
      adv();
      drive(ei(1'b0, z, mb(1'b1, 1'b0, 1'b0, 32'h6000, 8'h00), 8'hC3, 1'b1, 1'b0));
      @(negedge clk);
      chk("rst_abort_grant", 32'(grant), 32'd0);
      chk("rst_abort_s_bus", {s_cyc, s_stb, s_we, 29'd0}, 32'd0);
      chk("rst_abort_s_adr", s_adr, 32'd0);
      chk("rst_abort_m1", {30'd0, m1_ack, m1_stall}, 32'd1);
      chk("rst_abort_m0", {30'd0, m0_ack, m0_stall}, 32'd1);
      adv();
      @(negedge clk);
      chk("late_ack_regrant", 32'(grant), 32'd2);
      chk("late_ack_ignored", 32'(m1_ack), 32'd0);
      adv();
      drive(ei(1'b0, z, z, 8'h00, 1'b0, 1'b0));
      adv();
      adv();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
